spart_line_decoder: RTL and testbench
=====================================

// Module: spart_line_decoder
// PURPOSE
//  Serial-line receiver for the SPART 8N1 link: watches a txd line, recovers each frame with
//  16x oversampling, and presents bytes through a read-acknowledge handshake. Bench/debug
//  block: it sits on the wire between two SPARTs and checks what was sent.
//  Uses the same divisor encoding as SPART DB_HI:DB_LO, so one setting configures both ends.
// PARAMETERS
//  DIV_W        16  width of divisor input
//  SYNC_STAGES  2   flops in rxd synchroniser (>=2)
// PORTS
//  clk        in   1      system clock
//  rst        in   1      asynchronous, active-low reset
//  rxd        in   1      serial line (idle high), asynchronous to clk
//  div        in   DIV_W  16x-sample period in clk cycles (div==0 treated as 1)
//  rd_ack     in   1      host consumed rx_data; clears rda and overrun
//  rx_data    out  8      last good byte received, LSB first on the line
//  rda        out  1      level: unread byte in rx_data
//  overrun    out  1      sticky: good byte completed while rda=1
//  frame_err  out  1      1-cycle pulse: stop bit sampled low
//  busy       out  1      1 in any state other than IDLE
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, rx_data=8'h00, rda=0, overrun=0, frame_err=0, busy=0,
//   synchroniser flops=1, tick counter and sample counter=0.
//  rxd passes through SYNC_STAGES flops; rs = synchronised value. All decisions use rs.
//  Tick gen: down-counter loaded with div_l-1, 1-cycle tick when it hits 0; period = div_l
//   clocks. div_l = div (0 -> 1), captured on the IDLE->START transition, held for the frame.
//   Changes to div mid-frame take effect at the next frame.
//  FSM (sample counter sc counts ticks 0..15 within a bit):
//   IDLE : rs falling edge (prev=1, now=0) -> START; tick gen and sc cleared.
//   START: at the tick where sc==7 (mid start bit): rs==0 -> DATA, sc:=0, bit idx:=0;
//          rs==1 -> IDLE (glitch; no output).
//   DATA : at each tick where sc==15, shift rs into shift reg MSB-first-in (LSB of byte arrives
//          first); after 8th bit -> STOP.
//   STOP : at tick where sc==15: rs==1 -> IDLE, good byte; rs==0 -> frame_err pulse, -> BREAK.
//   BREAK: wait for rs==1 (any clock) -> IDLE. No new start detected while in BREAK.
//  Good byte: next clock rx_data<=shift reg, rda<=1; if rda already 1 and rd_ack not
//   asserted that cycle, overrun<=1 (new byte still overwrites rx_data).
//  rd_ack: rda<=0, overrun<=0 next clock. Same-cycle good byte + rd_ack: rda stays 1,
//   overrun not set (ack consumes the old byte).
//  rd_ack with rda=0: no effect.
//  frame_err is never combined with a good byte; rx_data and rda are unchanged on error.
//  Latency: rda rises 1 clock after the stop-bit sample tick,
//   i.e. ~9.5 bit times after the start edge (plus SYNC_STAGES clocks).
//  busy is registered: high from the clock after the start edge until IDLE is re-entered.
//  Reset mid-frame aborts immediately; partial byte discarded; no rda/frame_err afterwards.
// TESTING (div=4 -> 64 clks/bit unless noted; drive rxd from a bit-timed task or a SPART txd)
//  1 Send 8'h46 8N1 -> rda=1, rx_data=8'h46, frame_err never 1, busy=0 after stop.
//  2 Low glitch of 3*div clocks on idle line -> FSM back to IDLE, rda=0, no frame_err.
//  3 Send 8'h2C with stop bit forced 0, then hold line low 200 clks -> one frame_err pulse,
//     rda=0, busy=1 until line high; then 8'hA5 -> rx_data=8'hA5.
//  4 Send 8'h0A then 8'h55, no rd_ack -> rx_data=8'h55, rda=1, overrun=1;
//     rd_ack -> both 0.
//  5 Assert rst low midway through data bit 3 of 8'hFF -> all outputs 0 immediately;
//     after release, next 8'h81 received correctly.
//  6 div=0 and div=2604 (SPART cfg 16'h0A2C), send 8'h3C at matching rate -> rx_data=8'h3C.
//     Change div mid-frame -> current byte still correct.

Source files
------------

// File: rtl/spart_line_decoder.sv
// SPART 8N1 line receiver: synchronises rxd, recovers frames with 16x oversampling
// and hands completed bytes to a host through an rda / rd_ack handshake.
module spart_line_decoder #(
  parameter int DIV_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rxd,
  input  logic [DIV_W-1:0] div,
  input  logic             rd_ack,
  output logic [7:0]       rx_data,
  output logic             rda,
  output logic             overrun,
  output logic             frame_err,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rs_prev_q, rs_prev_d;
  state_e                 state_q, state_d;
  logic [DIV_W-1:0]       cnt_q, cnt_d;
  logic [DIV_W-1:0]       div_l_q, div_l_d;
  logic [3:0]             sc_q, sc_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rda_q, rda_d;
  logic                   overrun_q, overrun_d;
  logic                   frame_err_q, frame_err_d;
  logic                   busy_q, busy_d;

  logic                   rs;
  logic                   tick;
  logic                   good;
  logic [DIV_W-1:0]       div_eff;

  assign rs      = sync_q[SYNC_STAGES-1];
  assign div_eff = (div == '0) ? ONE : div;
  assign tick    = (state_q inside {S_START, S_DATA, S_STOP}) && (cnt_q == '0);

  // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], rxd};
    rs_prev_d   = rs;
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_l_d     = div_l_q;
    sc_d        = sc_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rda_d       = rda_q;
    overrun_d   = overrun_q;
    frame_err_d = 1'b0;
    good        = 1'b0;

    if (state_q inside {S_START, S_DATA, S_STOP}) begin
      cnt_d = tick ? (div_l_q - ONE) : (cnt_q - ONE);
    end

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        sc_d  = '0;
        if (rs_prev_q && !rs) begin
          state_d = S_START;
          div_l_d = div_eff;
          cnt_d   = div_eff - ONE;
        end
      end
      S_START: begin
        if (tick) begin
          sc_d = sc_q + 4'd1;
          if (sc_q == 4'd7) begin
            // A start bit that is high again at its midpoint was only a glitch.
            if (!rs) begin
              state_d   = S_DATA;
              sc_d      = '0;
              bit_idx_d = '0;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          sc_d = sc_q + 4'd1;
          if (sc_q == 4'd15) begin
            shift_d   = {rs, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          sc_d = sc_q + 4'd1;
          if (sc_q == 4'd15) begin
            if (rs) begin
              good    = 1'b1;
              state_d = S_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = S_BREAK;
            end
          end
        end
      end
      S_BREAK: begin
        if (rs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (rd_ack) begin
      rda_d     = 1'b0;
      overrun_d = 1'b0;
    end
    // An ack in the same cycle as a new byte consumes the old one, so no overrun.
    if (good) begin
      rx_data_d = shift_q;
      rda_d     = 1'b1;
      if (rda_q && !rd_ack) overrun_d = 1'b1;
    end

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only; all next values come from _d.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q      <= '1;
      rs_prev_q   <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      div_l_q     <= ONE;
      sc_q        <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rda_q       <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      rs_prev_q   <= rs_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_l_q     <= div_l_d;
      sc_q        <= sc_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rda_q       <= rda_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rda       = rda_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_spart_line_decoder.sv
// Directed bench for spart_line_decoder: bit-timed serial frames on rxd with
// hand-computed expectations for data, handshake, glitch, framing and reset cases.
module tb_spart_line_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rxd = 1'b1;
  logic [15:0] div = 16'd4;
  logic        rd_ack = 1'b0;
  logic [7:0]  rx_data;
  logic        rda, overrun, frame_err, busy;

  int vectors = 0;
  int miscompares = 0;
  int fe_count = 0;

  spart_line_decoder #(.DIV_W(16), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .div       (div),
    .rd_ack    (rd_ack),
    .rx_data   (rx_data),
    .rda       (rda),
    .overrun   (overrun),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err) fe_count++;

  // Drive one 8N1 frame; bit time is fixed from div at call start. chg_bit >= 0
  // rewrites div at the start of that bit position (0 = start bit).
  task automatic send_byte(input logic [7:0] b, input logic stop_v,
                           input int chg_bit, input logic [15:0] chg_div);
    int dv = (div == 16'd0) ? 1 : int'(div);
    logic [9:0] frame = {stop_v, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (i == chg_bit) div = chg_div;
      rxd = frame[i];
      repeat (16 * dv) @(negedge clk);
    end
    rxd = 1'b1;
  endtask

  task automatic pulse_ack();
    @(negedge clk) rd_ack = 1'b1;
    @(negedge clk) rd_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
    vectors++; if (rda !== 1'b0) begin miscompares++; $display("FAIL reset_rda got %b want 0", rda); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun got %b want 0", overrun); end
    vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_good_byte();
    int fe0 = fe_count;
    div = 16'd4;
    send_byte(8'h46, 1'b1, -1, 16'd0);
    repeat (4) @(negedge clk);
    vectors++; if (rx_data !== 8'h46) begin miscompares++; $display("FAIL good_rx_data got %h want 46", rx_data); end
    vectors++; if (rda !== 1'b1) begin miscompares++; $display("FAIL good_rda got %b want 1", rda); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL good_busy got %b want 0", busy); end
    vectors++; if (fe_count - fe0 !== 0) begin miscompares++; $display("FAIL good_frame_err pulses got %0d want 0", fe_count - fe0); end
    pulse_ack();
    vectors++; if (rda !== 1'b0) begin miscompares++; $display("FAIL ack_rda got %b want 0", rda); end
    vectors++; if (rx_data !== 8'h46) begin miscompares++; $display("FAIL ack_rx_data got %h want 46", rx_data); end
    pulse_ack();
    vectors++; if (rda !== 1'b0) begin miscompares++; $display("FAIL idle_ack_rda got %b want 0", rda); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL idle_ack_overrun got %b want 0", overrun); end
  endtask

  task automatic test_glitch();
    int fe0 = fe_count;
    div = 16'd4;
    rxd = 1'b0;
    repeat (6) @(negedge clk);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL glitch_busy_during got %b want 1", busy); end
    repeat (6) @(negedge clk);
    rxd = 1'b1;
    repeat (20 * 64) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL glitch_busy_after got %b want 0", busy); end
    vectors++; if (rda !== 1'b0) begin miscompares++; $display("FAIL glitch_rda got %b want 0", rda); end
    vectors++; if (fe_count - fe0 !== 0) begin miscompares++; $display("FAIL glitch_frame_err pulses got %0d want 0", fe_count - fe0); end
  endtask

  task automatic test_frame_error();
    int fe0 = fe_count;
    div = 16'd4;
    send_byte(8'h2C, 1'b0, -1, 16'd0);
    rxd = 1'b0;
    repeat (200) @(negedge clk);
    vectors++; if (fe_count - fe0 !== 1) begin miscompares++; $display("FAIL ferr_pulses got %0d want 1", fe_count - fe0); end
    vectors++; if (rda !== 1'b0) begin miscompares++; $display("FAIL ferr_rda got %b want 0", rda); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL ferr_busy_low_line got %b want 1", busy); end
    rxd = 1'b1;
    repeat (10) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ferr_busy_line_high got %b want 0", busy); end
    send_byte(8'hA5, 1'b1, -1, 16'd0);
    repeat (4) @(negedge clk);
    vectors++; if (rx_data !== 8'hA5) begin miscompares++; $display("FAIL ferr_next_rx_data got %h want a5", rx_data); end
    vectors++; if (rda !== 1'b1) begin miscompares++; $display("FAIL ferr_next_rda got %b want 1", rda); end
    pulse_ack();
  endtask

  task automatic test_overrun();
    div = 16'd4;
    send_byte(8'h0A, 1'b1, -1, 16'd0);
    send_byte(8'h55, 1'b1, -1, 16'd0);
    repeat (4) @(negedge clk);
    vectors++; if (rx_data !== 8'h55) begin miscompares++; $display("FAIL ovr_rx_data got %h want 55", rx_data); end
    vectors++; if (rda !== 1'b1) begin miscompares++; $display("FAIL ovr_rda got %b want 1", rda); end
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_overrun got %b want 1", overrun); end
    pulse_ack();
    vectors++; if (rda !== 1'b0) begin miscompares++; $display("FAIL ovr_ack_rda got %b want 0", rda); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_ack_overrun got %b want 0", overrun); end
  endtask

  task automatic test_reset_mid_frame();
    int fe0;
    div = 16'd4;
    rxd = 1'b0;
    repeat (64) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * 64 + 32) @(negedge clk);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rmid_busy_before got %b want 1", busy); end
    rst = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rmid_busy got %b want 0", busy); end
    vectors++; if (rda !== 1'b0) begin miscompares++; $display("FAIL rmid_rda got %b want 0", rda); end
    vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL rmid_rx_data got %h want 00", rx_data); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL rmid_overrun got %b want 0", overrun); end
    vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL rmid_frame_err got %b want 0", frame_err); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4 * 64) @(negedge clk);
    fe0 = fe_count;
    send_byte(8'h81, 1'b1, -1, 16'd0);
    repeat (4) @(negedge clk);
    vectors++; if (rx_data !== 8'h81) begin miscompares++; $display("FAIL rmid_next_rx_data got %h want 81", rx_data); end
    vectors++; if (rda !== 1'b1) begin miscompares++; $display("FAIL rmid_next_rda got %b want 1", rda); end
    vectors++; if (fe_count - fe0 !== 0) begin miscompares++; $display("FAIL rmid_frame_err pulses got %0d want 0", fe_count - fe0); end
    pulse_ack();
  endtask

  task automatic test_divisors();
    div = 16'd0;
    repeat (4) @(negedge clk);
    send_byte(8'h3C, 1'b1, -1, 16'd0);
    repeat (4) @(negedge clk);
    vectors++; if (rx_data !== 8'h3C) begin miscompares++; $display("FAIL div0_rx_data got %h want 3c", rx_data); end
    vectors++; if (rda !== 1'b1) begin miscompares++; $display("FAIL div0_rda got %b want 1", rda); end
    pulse_ack();
    // div switched to 9 during data bit 3; this frame must still decode at div 4.
    div = 16'd4;
    repeat (4) @(negedge clk);
    send_byte(8'hC3, 1'b1, 4, 16'd9);
    repeat (4) @(negedge clk);
    vectors++; if (rx_data !== 8'hC3) begin miscompares++; $display("FAIL divchg_rx_data got %h want c3", rx_data); end
    vectors++; if (rda !== 1'b1) begin miscompares++; $display("FAIL divchg_rda got %b want 1", rda); end
    pulse_ack();
    // Large divisor, scaled down from the 2604 setting to keep the run short.
    div = 16'h0100;
    repeat (4) @(negedge clk);
    send_byte(8'h3C, 1'b1, -1, 16'd0);
    repeat (4) @(negedge clk);
    vectors++; if (rx_data !== 8'h3C) begin miscompares++; $display("FAIL divbig_rx_data got %h want 3c", rx_data); end
    vectors++; if (rda !== 1'b1) begin miscompares++; $display("FAIL divbig_rda got %b want 1", rda); end
  endtask

  initial begin
    test_reset();
    test_good_byte();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_reset_mid_frame();
    test_divisors();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
